ps2_scancode_dec: RTL

Scan-code decoder stage directly downstream of the PS/2 receiver. Consumes one byte per `rcv_vld` pulse and tracks the multi-byte Set-2 prefixes (`E0` extended, `F0` break, `E1` pause). Emits one key event per complete sequence into a small event FIFO with a valid/ready interface toward the host. Device control bytes and parity errors are reported as single-cycle pulses.

---
 rtl/ps2_pkg.sv | 67 ++++++
 rtl/ps2_evt_fifo.sv | 55 +++++
 rtl/ps2_scancode_dec.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, event record and FSM encoding for the PS/2 Set-2 scan-code decoder.
package ps2_pkg;

   localparam logic [7:0] SC_E0 = 8'hE0;
   localparam logic [7:0] SC_F0 = 8'hF0;
   localparam logic [7:0] SC_E1 = 8'hE1;

   localparam logic [7:0] CTL_BAT_OK = 8'hAA;
   localparam logic [7:0] CTL_ACK    = 8'hFA;
   localparam logic [7:0] CTL_RESEND = 8'hFE;
   localparam logic [7:0] CTL_ECHO   = 8'hEE;
   localparam logic [7:0] CTL_ERR0   = 8'h00;
   localparam logic [7:0] CTL_ERR1   = 8'hFF;

   localparam logic [7:0] MOD_LSHIFT = 8'h12;
   localparam logic [7:0] MOD_RSHIFT = 8'h59;
   localparam logic [7:0] MOD_CTRL   = 8'h14;
   localparam logic [7:0] MOD_ALT    = 8'h11;

   localparam logic [7:0] PAUSE_CODE = 8'h77;
   // Pause carries seven bytes after E1; the counter value seen on the last one.
   localparam logic [2:0] PAUSE_LAST = 3'd6;

   localparam int EVT_W = 10;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      EXT     = 3'd1,
      BRK     = 3'd2,
      EXT_BRK = 3'd3,
      PAUSE   = 3'd4
   } state_t;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } evt_t;

   function automatic logic is_ctl_byte(input logic [7:0] b);
      logic hit;
      case (b)
         CTL_BAT_OK, CTL_ACK, CTL_RESEND,
         CTL_ECHO, CTL_ERR0, CTL_ERR1: hit = 1'b1;
         default:                      hit = 1'b0;
      endcase
      return hit;
   endfunction

   function automatic logic is_prefix(input logic [7:0] b);
      logic hit;
      case (b)
         SC_E0, SC_F0, SC_E1: hit = 1'b1;
         default:             hit = 1'b0;
      endcase
      return hit;
   endfunction

   function automatic evt_t make_evt(input logic ext, input logic brk, input logic [7:0] code);
      evt_t e;
      e.ext  = ext;
      e.brk  = brk;
      e.code = code;
      return e;
   endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO with wrap-bit pointers; head data is read straight from storage.
module ps2_evt_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_pop;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop    = pop && !empty;
   assign head_data = mem[rd_ptr[AW-1:0]];

   // Storage write; cleared on reset so the stale head reads as zero afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= {WIDTH{1'b0}};
         end
      end else if (push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   // Pointer update; the caller only pushes when there is room this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= {(AW+1){1'b0}};
         rd_ptr <= {(AW+1){1'b0}};
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/ps2_scancode_dec.sv
// PS/2 Set-2 scan-code decoder: prefix FSM, event FIFO, control/error pulses.
// Define PS2_SCANCODE_MOD_TRACK_EN to build the modifier (shift/ctrl/alt) tracker.
module ps2_scancode_dec
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rcv_data,
   input  logic       rcv_vld,
   input  logic       rcv_parity_err,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_brk,
   output logic       key_vld,
   input  logic       key_rdy,
   output logic       key_ovf,
   output logic       ctl_vld,
   output logic [7:0] ctl_code,
   output logic       err_pulse,
   output logic [3:0] mods
);

   state_t     state;
   logic [2:0] pause_cnt;
   logic       evt_push;
   evt_t       evt_data;
   logic       ctl_hit;
   logic       fifo_full;
   logic       fifo_empty;
   logic       fifo_wr;
   logic       key_pop;
   evt_t       head;

   assign key_vld  = !fifo_empty;
   assign key_pop  = key_vld && key_rdy;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign fifo_wr  = evt_push && (!fifo_full || key_pop);
   assign key_ext  = head.ext;
   assign key_brk  = head.brk;
   assign key_code = head.code;

   // Classify the incoming byte: completed event, control byte, or prefix/absorbed.
   always_comb begin
      evt_push = 1'b0;
      evt_data = make_evt(1'b0, 1'b0, 8'h00);
      ctl_hit  = 1'b0;
      if (rcv_vld && !rcv_parity_err) begin
         case (state)
            IDLE: begin
               if (is_prefix(rcv_data)) begin
                  evt_push = 1'b0;
               end else if (is_ctl_byte(rcv_data)) begin
                  ctl_hit = 1'b1;
               end else begin
                  evt_push = 1'b1;
                  evt_data = make_evt(1'b0, 1'b0, rcv_data);
               end
            end
            EXT: begin
               if (rcv_data == SC_F0) begin
                  evt_push = 1'b0;
               end else begin
                  evt_push = 1'b1;
                  evt_data = make_evt(1'b1, 1'b0, rcv_data);
               end
            end
            BRK: begin
               evt_push = 1'b1;
               evt_data = make_evt(1'b0, 1'b1, rcv_data);
            end
            EXT_BRK: begin
               evt_push = 1'b1;
               evt_data = make_evt(1'b1, 1'b1, rcv_data);
            end
            PAUSE: begin
               if (pause_cnt == PAUSE_LAST) begin
                  evt_push = 1'b1;
                  evt_data = make_evt(1'b1, 1'b0, PAUSE_CODE);
               end else begin
                  evt_push = 1'b0;
               end
            end
            default: begin
               evt_push = 1'b0;
            end
         endcase
      end else begin
         evt_push = 1'b0;
      end
   end

   // Prefix FSM and pause byte counter; a parity error abandons any partial sequence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pause_cnt <= 3'd0;
      end else if (rcv_vld) begin
         if (rcv_parity_err) begin
            state     <= IDLE;
            pause_cnt <= 3'd0;
         end else begin
            case (state)
               IDLE: begin
                  if (rcv_data == SC_E0) begin
                     state <= EXT;
                  end else if (rcv_data == SC_F0) begin
                     state <= BRK;
                  end else if (rcv_data == SC_E1) begin
                     state     <= PAUSE;
                     pause_cnt <= 3'd0;
                  end else begin
                     state <= IDLE;
                  end
               end
               EXT: begin
                  if (rcv_data == SC_F0) begin
                     state <= EXT_BRK;
                  end else begin
                     state <= IDLE;
                  end
               end
               BRK, EXT_BRK: begin
                  state <= IDLE;
               end
               PAUSE: begin
                  if (pause_cnt == PAUSE_LAST) begin
                     state     <= IDLE;
                     pause_cnt <= 3'd0;
                  end else begin
                     pause_cnt <= pause_cnt + 3'd1;
                  end
               end
               default: begin
                  state     <= IDLE;
                  pause_cnt <= 3'd0;
               end
            endcase
         end
      end
   end

   // Registered single-cycle status pulses and the held control code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctl_vld   <= 1'b0;
         ctl_code  <= 8'h00;
         err_pulse <= 1'b0;
         key_ovf   <= 1'b0;
      end else begin
         ctl_vld   <= ctl_hit;
         err_pulse <= rcv_vld && rcv_parity_err;
         key_ovf   <= evt_push && fifo_full && !key_pop;
         if (ctl_hit) begin
            ctl_code <= rcv_data;
         end
      end
   end

   ps2_evt_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_wr),
      .push_data (evt_data),
      .pop       (key_pop),
      .head_data (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef PS2_SCANCODE_MOD_TRACK_EN
   logic [3:0] mod_state;

   // Modifier tracking follows decoded events, including ones dropped on overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mod_state <= 4'b0000;
      end else if (evt_push) begin
         case (evt_data.code)
            MOD_LSHIFT: begin
               if (!evt_data.ext) begin
                  mod_state[0] <= !evt_data.brk;
               end
            end
            MOD_RSHIFT: begin
               if (!evt_data.ext) begin
                  mod_state[1] <= !evt_data.brk;
               end
            end
            MOD_CTRL: begin
               mod_state[2] <= !evt_data.brk;
            end
            MOD_ALT: begin
               mod_state[3] <= !evt_data.brk;
            end
            default: begin
               mod_state <= mod_state;
            end
         endcase
      end
   end

   assign mods = mod_state;
`else
   assign mods = 4'b0000;
`endif

endmodule
